// File: rtl/cdc_handshake_tx_if.sv
// Handshake/bus bundle for cdc_handshake_tx. The master modport is the transmitter;
// the slave modport is the local source and far-end side that drives it.
interface cdc_handshake_tx_if #(
    parameter int unsigned WIDTH = 32
);
    logic             valid_i;
    logic [WIDTH-1:0] data_i;
    logic             ready_o;
    logic             req_o;
    logic [WIDTH-1:0] data_o;
    logic             ack_i;
    logic             done_o;
    logic             timeout_o;

    modport master (
        input  valid_i, data_i, ack_i,
        output ready_o, req_o, data_o, done_o, timeout_o
    );

    modport slave (
        output valid_i, data_i, ack_i,
        input  ready_o, req_o, data_o, done_o, timeout_o
    );
endinterface

// File: rtl/cdc_handshake_tx.sv
// Source side of a 4-phase req/ack CDC handshake; holds data_o stable for the whole transfer.
// Optional ack-wait timeout is enabled with `define CDC_TX_TIMEOUT_EN.
module cdc_handshake_tx #(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned SYNC_REGS      = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input logic                 clk_i,
    input logic                 rst_i,
    cdc_handshake_tx_if.master  bus
);

    if (SYNC_REGS < 2 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("cdc_handshake_tx: SYNC_REGS and TIMEOUT_CYCLES must be at least 2");
    end

    typedef enum logic [1:0] {StIdle, StReq, StDrop} state_e;

    state_e               state_q, state_d;
    logic                 req_q, req_d;
    logic [WIDTH-1:0]     data_q, data_d;
    logic                 done_q, done_d;
    logic [SYNC_REGS-1:0] ack_sync_q;
    logic                 ack_s;

    // Plain flop chain; ack_i is the only asynchronous input.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ack_sync_q <= '0;
        end else begin
            ack_sync_q <= {ack_sync_q[SYNC_REGS-2:0], bus.ack_i};
        end
    end

    assign ack_s = ack_sync_q[SYNC_REGS-1];

`ifdef CDC_TX_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            timeout_q, timeout_d;
`endif

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        data_d  = data_q;
        done_d  = 1'b0;
`ifdef CDC_TX_TIMEOUT_EN
        timeout_d = timeout_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.valid_i) begin
                    data_d  = bus.data_i;
                    req_d   = 1'b1;
                    state_d = StReq;
                end
            end
            StReq: begin
                if (ack_s) begin
                    req_d   = 1'b0;
                    state_d = StDrop;
                end
`ifdef CDC_TX_TIMEOUT_EN
                else if (cnt_q == CntLast) begin
                    req_d     = 1'b0;
                    state_d   = StDrop;
                    timeout_d = 1'b1;
                end
`endif
            end
            StDrop: begin
                // Level check only: a stuck-high ack keeps us here.
                if (!ack_s) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
`ifdef CDC_TX_TIMEOUT_EN
                else if (cnt_q == CntLast) begin
                    state_d   = StIdle;
                    timeout_d = 1'b1;
                end
`endif
            end
            default: begin
                state_d = StIdle;
                req_d   = 1'b0;
            end
        endcase
`ifdef CDC_TX_TIMEOUT_EN
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q != StIdle) begin
            cnt_d = cnt_q + CntW'(1);
        end else begin
            cnt_d = cnt_q;
        end
`endif
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            req_q   <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

`ifdef CDC_TX_TIMEOUT_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.timeout_o = timeout_q;
`else
    assign bus.timeout_o = 1'b0;
`endif

    assign bus.ready_o = (state_q == StIdle);
    assign bus.req_o   = req_q;
    assign bus.data_o  = data_q;
    assign bus.done_o  = done_q;

endmodule
